// File: rtl/pkt_hdr_parse_if.sv
// Stream and header handshake bundle for pkt_hdr_parse.
// slave  : the parser's view (consumes ip_*, produces op_* and par_*).
// master : the environment's view (drives ip_*, op_drdy, par_drdy).
// Header word layout macros live here so the parser and its consumer agree.

`ifndef PAR_DATA_SZ
`define PAR_DATA_SZ 102
`define PAR_MACDA   47:0
`define PAR_MACSA   95:48
`define PAR_SRCPORT 101:96
`endif

interface pkt_hdr_parse_if;
    logic                    ip_srdy;
    logic                    ip_drdy;
    logic [7:0]              ip_data;
    logic                    ip_sop;
    logic                    ip_eop;
    logic                    op_srdy;
    logic                    op_drdy;
    logic [7:0]              op_data;
    logic                    op_sop;
    logic                    op_eop;
    logic                    par_srdy;
    logic                    par_drdy;
    logic [`PAR_DATA_SZ-1:0] par_data;

    modport slave (
        input  ip_srdy, ip_data, ip_sop, ip_eop, op_drdy, par_drdy,
        output ip_drdy, op_srdy, op_data, op_sop, op_eop, par_srdy, par_data
    );

    modport master (
        output ip_srdy, ip_data, ip_sop, ip_eop, op_drdy, par_drdy,
        input  ip_drdy, op_srdy, op_data, op_sop, op_eop, par_srdy, par_data
    );
endinterface

// File: rtl/pkt_hdr_parse.sv
// Per-port header parser: passes the byte stream through untouched and
// captures MAC DA / SA from bytes 0..11 into a single-entry header register
// presented on par_srdy/par_drdy.
// Optional statistics counters: define PKT_HDR_PARSE_STATS_EN.

module pkt_hdr_parse #(
    parameter logic [5:0] PORT_ID = 6'd0
) (
    input  logic                clk,
    input  logic                reset,
    pkt_hdr_parse_if.slave      bus,
    output logic [15:0]         runt_cnt,
    output logic [15:0]         pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_HDR  = 3'b010,
        S_BODY = 3'b100
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              ctr_q, ctr_d;
    logic [47:0]             da_q, da_d;
    logic [47:0]             sa_q, sa_d;
    logic                    par_srdy_q, par_srdy_d;
    logic [`PAR_DATA_SZ-1:0] par_data_q, par_data_d;
    logic [`PAR_DATA_SZ-1:0] hdr_word;
    logic                    stall, xfer, hdr_ld, runt_ev;

    // Only byte 11 can stall: it would overwrite an unconsumed header.
    assign stall = (state_q == S_HDR) && (ctr_q == 4'd11) && par_srdy_q && !bus.par_drdy;
    assign xfer  = bus.ip_srdy && bus.ip_drdy;

    // Combinational pass-through path.
    always_comb begin
        bus.ip_drdy = bus.op_drdy && !stall;
        bus.op_srdy = bus.ip_srdy && !stall;
        bus.op_data = bus.ip_data;
        bus.op_sop  = bus.ip_sop;
        bus.op_eop  = bus.ip_eop;
    end

    // Header word assembled from DA and the SA including the byte now transferring.
    always_comb begin
        hdr_word               = '0;
        hdr_word[`PAR_MACDA]   = da_q;
        hdr_word[`PAR_MACSA]   = {sa_q[39:0], bus.ip_data};
        hdr_word[`PAR_SRCPORT] = PORT_ID;
    end

    // Next-state: capture sequencing, runt detection, header load.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        da_d    = da_q;
        sa_d    = sa_q;
        hdr_ld  = 1'b0;
        runt_ev = 1'b0;
        unique case (state_q)
            S_IDLE, S_BODY: begin
                if (xfer) begin
                    if (bus.ip_sop) begin
                        if (bus.ip_eop) begin
                            runt_ev = 1'b1;
                            state_d = S_IDLE;
                            ctr_d   = 4'd0;
                        end else begin
                            da_d    = {40'h0, bus.ip_data};
                            ctr_d   = 4'd1;
                            state_d = S_HDR;
                        end
                    end else if (bus.ip_eop) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HDR: begin
                if (xfer) begin
                    if (bus.ip_sop) begin
                        // New packet preempts the partial header.
                        runt_ev = 1'b1;
                        if (bus.ip_eop) begin
                            state_d = S_IDLE;
                            ctr_d   = 4'd0;
                        end else begin
                            da_d  = {40'h0, bus.ip_data};
                            ctr_d = 4'd1;
                        end
                    end else if (ctr_q == 4'd11) begin
                        sa_d    = {sa_q[39:0], bus.ip_data};
                        hdr_ld  = 1'b1;
                        ctr_d   = 4'd0;
                        state_d = bus.ip_eop ? S_IDLE : S_BODY;
                    end else if (bus.ip_eop) begin
                        runt_ev = 1'b1;
                        ctr_d   = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        if (ctr_q < 4'd6) da_d = {da_q[39:0], bus.ip_data};
                        else              sa_d = {sa_q[39:0], bus.ip_data};
                        ctr_d = ctr_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ctr_d   = 4'd0;
            end
        endcase
    end

    // Header output register: load wins over a same-cycle consume.
    always_comb begin
        par_srdy_d = hdr_ld || (par_srdy_q && !bus.par_drdy);
        par_data_d = hdr_ld ? hdr_word : par_data_q;
    end

    // Parser state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctr_q      <= 4'd0;
            da_q       <= '0;
            sa_q       <= '0;
            par_srdy_q <= 1'b0;
            par_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            da_q       <= da_d;
            sa_q       <= sa_d;
            par_srdy_q <= par_srdy_d;
            par_data_q <= par_data_d;
        end
    end

    assign bus.par_srdy = par_srdy_q;
    assign bus.par_data = par_data_q;

`ifdef PKT_HDR_PARSE_STATS_EN
    logic [15:0] runt_cnt_q, pkt_cnt_q;

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            runt_cnt_q <= 16'h0;
            pkt_cnt_q  <= 16'h0;
        end else begin
            if (runt_ev && runt_cnt_q != 16'hFFFF) runt_cnt_q <= runt_cnt_q + 16'h1;
            if (hdr_ld  && pkt_cnt_q  != 16'hFFFF) pkt_cnt_q  <= pkt_cnt_q  + 16'h1;
        end
    end

    assign runt_cnt = runt_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
`else
    logic unused_ev;
    assign unused_ev = runt_ev;
    assign runt_cnt  = 16'h0;
    assign pkt_cnt   = 16'h0;
`endif

endmodule

// File: doc/pkt_hdr_parse.md
# pkt_hdr_parse

Per-port header parser directly upstream of `fib_lookup_fsm`. It snoops a byte-wide packet stream from one bridge port and passes every byte through unchanged to the port's packet buffer. It extracts MAC DA and MAC SA from the first 12 bytes and presents them, tagged with the source port, as one `PAR_DATA_SZ` word on an srdy/drdy interface. That interface feeds the FIB lookup's `lpp_*` inputs.

## Interface
- PORT_ID, 0, source port number written into the `PAR_SRCPORT` field
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- ip_srdy  input  1  ingress byte valid
- ip_drdy  output  1  ingress byte accepted
- ip_data  input  8  ingress byte
- ip_sop  input  1  byte is first of packet
- ip_eop  input  1  byte is last of packet
- op_srdy  output  1  pass-through byte valid
- op_drdy  input  1  pass-through consumer ready
- op_data  output  8  pass-through byte (= ip_data)
- op_sop, op_eop  output  1 each  pass-through flags (= ip_sop, ip_eop)
- par_srdy  output  1  header word valid (to lpp_srdy)
- par_drdy  input  1  header consumed (from lpp_drdy)
- par_data  output  `PAR_DATA_SZ`  fields `PAR_MACDA`, `PAR_MACSA`, `PAR_SRCPORT`; other bits 0
- runt_cnt  output  16  runt packets seen (only with PKT_HDR_PARSE_STATS_EN)
- pkt_cnt  output  16  headers emitted (only with PKT_HDR_PARSE_STATS_EN)

## Operation
- Transfer: a byte moves when ip_srdy & ip_drdy. The pass-through path is combinational.
  - op_srdy = ip_srdy & ~stall
  - ip_drdy = op_drdy & ~stall
  - op_* data and flags mirror ip_*.
- stall = (state==s_hdr) & (byte_ctr==11) & par_srdy & ~par_drdy. This single-entry output is never overwritten.
- States (one-hot):
  - s_idle: waiting for SOP.
    - A transferred byte with sop and no eop: load byte into DA[47:40], byte_ctr=1, go to s_hdr.
    - A byte with sop & eop: runt, stay in s_idle.
    - A byte without sop: passed through, ignored, stay in s_idle.
  - s_hdr: bytes 1–5 shift into DA and bytes 6–11 into SA, MSB first; byte_ctr increments on each transfer.
    - On transfer of byte 11: load par_data and set par_srdy. Go to s_idle if eop, else to s_body.
    - eop on bytes 1–10: runt, no header emitted, go to s_idle.
    - sop on bytes 1–11: abandon the current header, count a runt, restart capture at byte 0 (DA[47:40]) and stay in s_hdr.
  - s_body: pass bytes through until eop, then go to s_idle.
    - A sop byte in s_body starts a new header exactly as in s_idle.
- par_srdy clears on par_srdy & par_drdy. If a new header loads in the same cycle, par_srdy stays 1 with the new data.
- par_data holds stable while par_srdy=1.

## Timing
- Reset values: state=s_idle, byte_ctr=0, par_srdy=0, par_data=0, runt_cnt=0, pkt_cnt=0.
  - ip_drdy and op_srdy follow their combinational equations; with par_srdy=0, stall=0.
- Header latency: par_srdy=1 in the cycle after byte 11 transfers.
- Throughput: one byte per cycle. Minimum packet spacing is not enforced.
- Back-to-back 12-byte packets only stall if the previous header has not yet been consumed.
- Reset asserted mid-packet clears all state immediately. Bytes after reset are ignored until the next sop.
- Counters saturate at 16'hFFFF.

## Configuration
- PKT_HDR_PARSE_STATS_EN
  - Defined: runt_cnt and pkt_cnt are implemented. pkt_cnt increments when a header loads; runt_cnt increments on every runt event above.
  - Undefined: both outputs tie to 0 and no counter flops exist. Parsing behaviour is identical.

## Test plan
- 64-byte packet, DA=01_02_03_04_05_06, SA=0A_0B_0C_0D_0E_0F, PORT_ID=2 -> all 64 bytes appear on op_* in order; par_srdy rises the cycle after byte 11; par_data has those DA/SA values and SRCPORT=2; pkt_cnt=1.
- Two 12-byte packets back-to-back with par_drdy=0 -> the second packet stalls at byte 11 (ip_drdy=0). Raise par_drdy for one cycle -> the first header is consumed, the second byte 11 transfers, and the second header appears the next cycle.
- 8-byte packet (eop at byte 7) -> no par_srdy; runt_cnt=1; all 8 bytes pass through.
- sop at byte 5 of a header, then a full 20-byte packet -> one header carrying the second packet's DA/SA; runt_cnt=1.
- op_drdy toggling 0/1 every cycle through a 16-byte packet -> byte order and par_data are correct; no byte is duplicated or lost.
- reset asserted at byte 7, released, then a valid packet -> par_srdy stays 0 until the new header; par_data reflects only the new packet.
